// File: rtl/cover_toggle_collector.sv
`default_nettype none
// ============================================================================
// Module   : cover_toggle_collector
// Purpose  : Receiving end of the toggle-coverage path. Hit events (a base
//            cover index plus a WIDTH-bit hit vector) are queued in a small
//            FIFO and folded into a sticky bitmap of COVER_TOTAL flops. On
//            request the bitmap is cleared word by word or streamed out over
//            a valid/ready port.
// Ports    : clock, reset          - single clock, synchronous active-high reset
//            in_valid/in_ready     - event handshake
//            in_index/in_bits      - base index and hit vector (bit i -> index+i)
//            clear_req/dump_req    - one-cycle request pulses
//            busy                  - operation running or pending
//            out_valid/out_ready   - dump word handshake
//            out_addr/out_data     - dump word address and contents
//            out_last              - final dump word
//            range_err             - sticky: a hit fell beyond COVER_TOTAL
//            hit_count             - unique hits (COVER_UNIQUE_COUNT_EN only)
// Options  : `define COVER_UNIQUE_COUNT_EN adds the hit_count output.
// Revision : 1.0 - initial release
// ============================================================================
module cover_toggle_collector #(
    parameter int COVER_TOTAL = 28338,
    parameter int WIDTH       = 5,
    parameter int WORD        = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int IDX_W       = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    input  logic [WIDTH-1:0] in_bits,
    input  logic             clear_req,
    input  logic             dump_req,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       out_addr,
    output logic [WORD-1:0]  out_data,
    output logic             out_last,
    output logic             range_err
`ifdef COVER_UNIQUE_COUNT_EN
    ,
    output logic [IDX_W:0]   hit_count
`endif
);

    localparam int NWORDS = (COVER_TOTAL + WORD - 1) / WORD;
    localparam int AW     = 10;
    localparam int WSH    = $clog2(WORD);
    localparam int DW     = 2 * WORD;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int TAIL   = COVER_TOTAL - (NWORDS - 1) * WORD;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NWORDS - 1);
    localparam logic [WORD-1:0] LAST_MASK = {WORD{1'b1}} >> (WORD - TAIL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WORD-1:0]  r_bitmap    [NWORDS];
    logic [IDX_W-1:0] r_fifo_idx  [FIFO_DEPTH];
    logic [WIDTH-1:0] r_fifo_bits [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_clear_pend;
    logic             r_dump_pend;
    logic             r_range_err;
    logic [AW-1:0]    r_addr;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_enter_clear;
    logic             w_enter_dump;

    // Head-of-FIFO decode
    logic [IDX_W-1:0] w_idx;
    logic [WIDTH-1:0] w_bits;
    logic [WIDTH-1:0] w_vbits;
    logic             w_oor;
    logic [AW-1:0]    w_w0;
    logic [AW-1:0]    w_w1;
    logic             w_w0_ok;
    logic             w_w1_ok;
    logic [DW-1:0]    w_sh;
    logic [WORD-1:0]  w_lo;
    logic [WORD-1:0]  w_hi;
    logic [WORD-1:0]  w_old_lo;
    logic [WORD-1:0]  w_old_hi;

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !reset && !w_full && !r_clear_pend && !r_dump_pend
                      && (r_state == ST_IDLE);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == ST_IDLE) && !w_empty;

    assign w_idx  = r_fifo_idx[r_rd_ptr];
    assign w_bits = r_fifo_bits[r_rd_ptr];

    // Keep only hits that land on a real cover point; the rest flag range_err.
    always_comb begin
        w_vbits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_vbits[i] = w_bits[i] && ((32'(w_idx) + 32'(i)) < 32'(COVER_TOTAL));
        end
    end
    assign w_oor = |(w_bits & ~w_vbits);

    // An event spans at most two words: the base word and the one after it.
    assign w_w0    = AW'(w_idx >> WSH);
    assign w_w1    = w_w0 + AW'(1);
    assign w_w0_ok = (32'(w_w0) < 32'(NWORDS));
    assign w_w1_ok = ((32'(w_w0) + 32'd1) < 32'(NWORDS));
    assign w_sh    = DW'(w_vbits) << w_idx[WSH-1:0];
    assign w_lo    = w_sh[WORD-1:0];
    assign w_hi    = w_sh[DW-1:WORD];
    assign w_old_lo = w_w0_ok ? r_bitmap[w_w0] : '0;
    assign w_old_hi = w_w1_ok ? r_bitmap[w_w1] : '0;

    // FSM: leave IDLE only with the FIFO drained; clear beats dump.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_empty) begin
                    if (r_clear_pend) begin
                        w_state_next = ST_CLEAR;
                    end else if (r_dump_pend) begin
                        w_state_next = ST_DUMP;
                    end
                end
            end
            ST_CLEAR: begin
                if (r_addr == LAST_ADDR) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DUMP: begin
                if (out_ready && (r_addr == LAST_ADDR)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_enter_clear = (r_state == ST_IDLE) && (w_state_next == ST_CLEAR);
    assign w_enter_dump  = (r_state == ST_IDLE) && (w_state_next == ST_DUMP);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_clear_pend <= 1'b0;
            r_dump_pend  <= 1'b0;
            r_range_err  <= 1'b0;
            r_addr       <= '0;
        end else begin
            if (w_push) begin
                r_fifo_idx[r_wr_ptr]  <= in_index;
                r_fifo_bits[r_wr_ptr] <= in_bits;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            // A request for the operation already running is dropped.
            if (w_enter_clear) begin
                r_clear_pend <= 1'b0;
            end else if (clear_req && (r_state != ST_CLEAR)) begin
                r_clear_pend <= 1'b1;
            end
            if (w_enter_dump) begin
                r_dump_pend <= 1'b0;
            end else if (dump_req && (r_state != ST_DUMP)) begin
                r_dump_pend <= 1'b1;
            end

            if (w_enter_clear) begin
                r_range_err <= 1'b0;
            end else if (w_pop && w_oor) begin
                r_range_err <= 1'b1;
            end

            // Shared word pointer: sweeps in CLEAR, advances on handshake in DUMP.
            if ((r_state == ST_CLEAR) || ((r_state == ST_DUMP) && out_ready)) begin
                r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_bitmap[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_bitmap[r_addr] <= '0;
        end else if (w_pop) begin
            if (w_w0_ok) begin
                r_bitmap[w_w0] <= w_old_lo | w_lo;
            end
            if (w_w1_ok) begin
                r_bitmap[w_w1] <= w_old_hi | w_hi;
            end
        end
    end

`ifdef COVER_UNIQUE_COUNT_EN
    logic [IDX_W:0] r_hit_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count <= '0;
        end else if (w_enter_clear) begin
            r_hit_count <= '0;
        end else if (w_pop) begin
            r_hit_count <= r_hit_count
                         + (IDX_W+1)'($countones(w_lo & ~w_old_lo))
                         + (IDX_W+1)'($countones(w_hi & ~w_old_hi));
        end
    end
    assign hit_count = r_hit_count;
`endif

    assign busy      = (r_state != ST_IDLE) || r_clear_pend || r_dump_pend;
    assign out_valid = (r_state == ST_DUMP);
    assign out_addr  = out_valid ? r_addr : '0;
    assign out_last  = out_valid && (r_addr == LAST_ADDR);
    // Tail bits of the final word are not cover points and always read 0.
    assign out_data  = !out_valid              ? '0 :
                       (r_addr == LAST_ADDR)   ? (r_bitmap[r_addr] & LAST_MASK) :
                                                 r_bitmap[r_addr];
    assign range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_cover_toggle_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cover_toggle_collector
// Purpose  : Self-checking bench for cover_toggle_collector. A bit-array
//            reference model of the cover points produces the expected dump
//            words; a monitor pops them as the DUT hands words over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cover_toggle_collector;

    localparam int CT = 28338;
    localparam int NW = 886;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_index;
    logic [4:0]  in_bits;
    logic        clear_req;
    logic        dump_req;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        range_err;
`ifdef COVER_UNIQUE_COUNT_EN
    logic [15:0] hit_count;
`endif

    cover_toggle_collector dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_bits   (in_bits),
        .clear_req (clear_req),
        .dump_req  (dump_req),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last),
        .range_err (range_err)
`ifdef COVER_UNIQUE_COUNT_EN
        ,
        .hit_count (hit_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    bit          model [CT];
    bit          m_rerr;
    logic [31:0] seen [NW];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ready_mode = 1;
    int          ready_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_apply(input int idx, input logic [4:0] bits);
        for (int i = 0; i < 5; i++) begin
            if (bits[i]) begin
                if (idx + i < CT) model[idx + i] = 1'b1;
                else m_rerr = 1'b1;
            end
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < CT; i++) model[i] = 1'b0;
        m_rerr = 1'b0;
    endfunction

    function automatic int model_pop();
        int n = 0;
        for (int i = 0; i < CT; i++) n += int'(model[i]);
        return n;
    endfunction

    // Snapshot the model as the full sequence of dump words.
    function automatic void push_expect();
        for (int w = 0; w < NW; w++) begin
            exp_t e;
            e.addr = 10'(w);
            e.data = '0;
            for (int j = 0; j < 32; j++) begin
                if (w * 32 + j < CT) e.data[j] = model[w * 32 + j];
            end
            e.last = (w == NW - 1);
            exp_q.push_back(e);
        end
    endfunction

    // out_ready pattern: 0 never, 1 always, 2 one cycle in three, 3 random.
    always @(negedge clock) begin
        ready_cnt++;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = (ready_cnt % 3 == 0);
            default: out_ready = 1'($urandom_range(1, 0));
        endcase
    end

    // Monitor: compares each handshaken dump word against the scoreboard.
    logic        stalled_prev = 1'b0;
    logic        last_prev    = 1'b0;
    logic [9:0]  hold_addr;
    logic [31:0] hold_data;
    logic        hold_last;

    always @(negedge clock) begin
        #2;
        if (reset) begin
            stalled_prev = 1'b0;
            last_prev    = 1'b0;
        end else begin
            if (stalled_prev && out_valid) begin
                check("hold_addr", 64'(out_addr), 64'(hold_addr));
                check("hold_data", 64'(out_data), 64'(hold_data));
                check("hold_last", 64'(out_last), 64'(hold_last));
            end
            if (last_prev) begin
                check("post_last_valid", 64'(out_valid), 64'd0);
                check("post_last_busy", 64'(busy), 64'd0);
                last_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("dump_unexpected_word", 64'(out_addr), 64'h3ff_0000);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("dump_addr", 64'(out_addr), 64'(e.addr));
                    check("dump_data", 64'(out_data), 64'(e.data));
                    check("dump_last", 64'(out_last), 64'(e.last));
                    seen[e.addr] = out_data;
                    if (out_last) last_prev = 1'b1;
                end
            end
            stalled_prev = out_valid && !out_ready;
            hold_addr    = out_addr;
            hold_data    = out_data;
            hold_last    = out_last;
        end
    end

    task automatic send_event(input int idx, input logic [4:0] bits);
        int n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_index = 15'(idx);
        in_bits  = bits;
        #1;
        while (!in_ready && n < 5000) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!in_ready) check("event_accept_timeout", 64'd0, 64'd1);
        else model_apply(idx, bits);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic do_dump();
        @(negedge clock);
        dump_req = 1'b1;
        push_expect();
        @(negedge clock);
        dump_req = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clock);
            #3;
            n++;
        end while ((busy || exp_q.size() != 0) && n < 20000);
        if (busy || exp_q.size() != 0) check("wait_done_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic settle();
        repeat (4) @(negedge clock);
        #3;
    endtask

    int          ev_idx  [5] = '{100, 131, 5000, 28333, 777};
    logic [4:0]  ev_bits [5] = '{5'b00001, 5'b10101, 5'b11000, 5'b11111, 5'b01110};

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_index = '0; in_bits = '0;
        clear_req = 1'b0; dump_req = 1'b0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("ready_in_reset", 64'(in_ready), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("ready_after_reset", 64'(in_ready), 64'd1);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_addr", 64'(out_addr), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_last", 64'(out_last), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rerr", 64'(range_err), 64'd0);
`ifdef COVER_UNIQUE_COUNT_EN
        check("reset_hit_count", 64'(hit_count), 64'd0);
`endif

        // Empty bitmap dump
        ready_mode = 1;
        do_dump();
        wait_done();

        // Event straddling words 0/1
        send_event(30, 5'b11111);
        settle();
`ifdef COVER_UNIQUE_COUNT_EN
        check("hit_count_5", 64'(hit_count), 64'd5);
`endif
        do_dump();
        wait_done();
        check("word0", 64'(seen[0]), 64'hC000_0000);
        check("word1", 64'(seen[1]), 64'h0000_0007);

        // Event at the top of the index range
        send_event(28336, 5'b00111);
        settle();
        check("range_err_top", 64'(range_err), 64'd1);
`ifdef COVER_UNIQUE_COUNT_EN
        check("hit_count_7", 64'(hit_count), 64'd7);
`endif
        do_dump();
        wait_done();
        check("word885", 64'(seen[NW-1]), 64'h0003_0000);

        // Back-to-back events with dump_req on the fourth
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_index = 15'(ev_idx[k]);
            in_bits  = ev_bits[k];
            dump_req = (k == 3);
            #1;
            check("b2b_ready", 64'(in_ready), 64'd1);
            if (in_ready) model_apply(ev_idx[k], ev_bits[k]);
            if (k == 3) push_expect();
            @(negedge clock);
        end
        dump_req = 1'b0;
        in_index = 15'(ev_idx[4]);
        in_bits  = ev_bits[4];
        #1;
        check("ready_drop_on_dump", 64'(in_ready), 64'd0);
        begin
            int n = 0;
            while (!in_ready && n < 5000) begin
                @(negedge clock);
                #1;
                n++;
            end
            if (!in_ready) check("fifth_accept_timeout", 64'd0, 64'd1);
            else model_apply(ev_idx[4], ev_bits[4]);
        end
        @(negedge clock);
        in_valid = 1'b0;
        wait_done();
        do_dump();
        wait_done();

        // Stalled dump, one ready cycle in three
        ready_mode = 2;
        do_dump();
        wait_done();

        // Random events, random back-pressure
        for (int k = 0; k < 40; k++) begin
            int idx;
            if (k % 4 == 0) idx = int'($urandom_range(NW - 1, 0)) * 32 + int'($urandom_range(31, 27));
            else idx = int'($urandom_range(CT + 8, 0));
            send_event(idx, 5'($urandom_range(31, 0)));
        end
        settle();
        check("range_err_random", 64'(range_err), 64'(m_rerr));
`ifdef COVER_UNIQUE_COUNT_EN
        check("hit_count_random", 64'(hit_count), 64'(model_pop()));
`endif
        ready_mode = 3;
        do_dump();
        wait_done();

        // Clear and dump requested in the same cycle
        ready_mode = 1;
        @(negedge clock);
        clear_req = 1'b1;
        dump_req  = 1'b1;
        model_clear();
        push_expect();
        @(negedge clock);
        clear_req = 1'b0;
        dump_req  = 1'b0;
        begin
            int k = 0;
            #3;
            while (!out_valid && k < 2000) begin
                if (k == 3) begin
                    check("clear_busy", 64'(busy), 64'd1);
                    check("clear_rerr", 64'(range_err), 64'd0);
`ifdef COVER_UNIQUE_COUNT_EN
                    check("clear_hit_count", 64'(hit_count), 64'd0);
`endif
                end
                @(negedge clock);
                #3;
                k++;
            end
            check("clear_len_ok", 64'((k >= NW + 1) && (k <= NW + 5)), 64'd1);
        end
        wait_done();
        check("rerr_after_clear", 64'(range_err), 64'd0);

        // Reset in the middle of a dump
        send_event(64, 5'b10011);
        send_event(9000, 5'b00101);
        settle();
        do_dump();
        repeat (20) @(negedge clock);
        ready_mode = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_addr", 64'(out_addr), 64'd0);
        check("abort_rerr", 64'(range_err), 64'd0);
        ready_mode = 1;
        do_dump();
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
